// File: rtl/can_tx_frame_loader_if.sv
// -----------------------------------------------------------------------------
// can_tx_frame_loader_if
// Purpose : frame descriptor handshake between a host (master) and the CAN TX
//           frame loader (slave). A descriptor transfers when valid & ready.
// Signals : req_valid  descriptor valid            (master -> slave)
//           req_ready  descriptor accepted         (slave  -> master)
//           req_ide    1 = 29-bit ID, 0 = 11-bit ID
//           req_rtr    remote frame
//           req_dlc    data length code
//           req_id     identifier (std ID in [10:0])
//           req_data   payload, byte0 = [7:0] ... byte7 = [63:56]
// -----------------------------------------------------------------------------
interface can_tx_frame_loader_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_ide;
   logic        req_rtr;
   logic [3:0]  req_dlc;
   logic [28:0] req_id;
   logic [63:0] req_data;

   modport master (
      output req_valid, req_ide, req_rtr, req_dlc, req_id, req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_ide, req_rtr, req_dlc, req_id, req_data,
      output req_ready
   );
endinterface

// File: rtl/can_tx_frame_loader.sv
// -----------------------------------------------------------------------------
// can_tx_frame_loader
// Purpose : host-side sequencer for an SJA1000 PeliCAN core. Accepts one frame
//           descriptor, polls SR until the TX buffer is free, loads frame info,
//           ID and data into the TX buffer, requests transmission via CMR and
//           polls SR until transmission completes. A TX timeout aborts the frame.
// Ports   : clk_i             system clock
//           reg_rst_i         synchronous reset, active-high
//           req               descriptor handshake (slave modport)
//           reg_we_o / reg_addr_write_o / reg_data_o   core register write
//           reg_re_o / reg_addr_read_o / reg_data_i    core register read
//           tx_we_o / tx_addr_o / tx_data_o            TX buffer byte write
//           busy_o            high from accept until done_o
//           done_o            one-cycle completion pulse
//           status_o          00 ok, 01 TX buffer never free, 10 TX aborted
// -----------------------------------------------------------------------------
module can_tx_frame_loader #(
   parameter int unsigned RD_LAT      = 1,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic                         clk_i,
   input  logic                         reg_rst_i,
   can_tx_frame_loader_if.slave         req,
   output logic                         reg_we_o,
   output logic [7:0]                   reg_addr_write_o,
   output logic [7:0]                   reg_data_o,
   output logic                         reg_re_o,
   output logic [7:0]                   reg_addr_read_o,
   input  logic [7:0]                   reg_data_i,
   output logic                         tx_we_o,
   output logic [3:0]                   tx_addr_o,
   output logic [7:0]                   tx_data_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic [1:0]                   status_o
);

   localparam logic [7:0]  AddrCmr    = 8'd1;
   localparam logic [7:0]  AddrSr     = 8'd2;
   localparam logic [7:0]  LatLast    = 8'(RD_LAT - 1);
   localparam logic [15:0] TimeoutVal = 16'(TIMEOUT_CYC);

   typedef enum logic [3:0] {
      StIdle, StTbsRd, StTbsWt, StLoad, StCmd, StTcsRd, StTcsWt, StAbort, StDone
   } state_t;

   state_t      r_state, w_state_d;
   logic        r_ide, r_rtr;
   logic [3:0]  r_dlc;
   logic [28:0] r_id;
   logic [63:0] r_data;
   logic [15:0] r_cnt;
   logic [7:0]  r_wait;
   logic [3:0]  r_idx;
   logic [1:0]  r_status, w_status_d;

   logic [3:0]  w_nbytes, w_hdr, w_last, w_dsel;
   logic [7:0]  w_tx_byte;
   logic        w_sample, w_timeout, w_poll;
   logic        w_unused_rd;

   // Only TBS (bit2) and TCS (bit3) of SR matter here.
   assign w_unused_rd = ^{reg_data_i[7:4], reg_data_i[1:0]};

   // dlc 9..15 still carries 8 data bytes; remote frames carry none.
   assign w_nbytes  = r_rtr ? 4'd0 : ((r_dlc > 4'd8) ? 4'd8 : r_dlc);
   assign w_hdr     = r_ide ? 4'd5 : 4'd3;
   assign w_last    = w_hdr + w_nbytes - 4'd1;
   assign w_dsel    = r_idx - w_hdr;
   assign w_sample  = (r_wait == LatLast);
   assign w_timeout = (r_cnt >= TimeoutVal);
   assign w_poll    = (r_state == StTbsRd) || (r_state == StTbsWt) ||
                      (r_state == StTcsRd) || (r_state == StTcsWt);

   always_comb begin
      w_tx_byte = 8'h00;
      if (r_idx == 4'd0) begin
         w_tx_byte = {r_ide, r_rtr, 2'b00, r_dlc};
      end else if (r_idx < w_hdr) begin
         if (r_ide) begin
            case (r_idx)
               4'd1:    w_tx_byte = r_id[28:21];
               4'd2:    w_tx_byte = r_id[20:13];
               4'd3:    w_tx_byte = r_id[12:5];
               default: w_tx_byte = {r_id[4:0], 3'b000};
            endcase
         end else begin
            w_tx_byte = (r_idx == 4'd1) ? r_id[10:3] : {r_id[2:0], 5'b00000};
         end
      end else begin
         w_tx_byte = r_data[{w_dsel[2:0], 3'b000} +: 8];
      end
   end

   always_comb begin
      w_state_d        = r_state;
      w_status_d       = r_status;
      req.req_ready    = 1'b0;
      reg_we_o         = 1'b0;
      reg_addr_write_o = 8'h00;
      reg_data_o       = 8'h00;
      reg_re_o         = 1'b0;
      reg_addr_read_o  = 8'h00;
      tx_we_o          = 1'b0;
      tx_addr_o        = 4'h0;
      tx_data_o        = 8'h00;
      done_o           = 1'b0;
      unique case (r_state)
         StIdle: begin
            req.req_ready = 1'b1;
            if (req.req_valid) w_state_d = StTbsRd;
         end
         StTbsRd: begin
            reg_re_o        = 1'b1;
            reg_addr_read_o = AddrSr;
            w_state_d       = StTbsWt;
         end
         StTbsWt: begin
            if (w_sample) begin
               if (reg_data_i[2]) begin
                  w_state_d = StLoad;
               end else if (w_timeout) begin
                  w_state_d  = StDone;
                  w_status_d = 2'b01;
               end else begin
                  w_state_d = StTbsRd;
               end
            end
         end
         StLoad: begin
            tx_we_o   = 1'b1;
            tx_addr_o = r_idx;
            tx_data_o = w_tx_byte;
            if (r_idx == w_last) w_state_d = StCmd;
         end
         StCmd: begin
            reg_we_o         = 1'b1;
            reg_addr_write_o = AddrCmr;
            reg_data_o       = 8'h01;
            w_state_d        = StTcsRd;
         end
         StTcsRd: begin
            reg_re_o        = 1'b1;
            reg_addr_read_o = AddrSr;
            w_state_d       = StTcsWt;
         end
         StTcsWt: begin
            if (w_sample) begin
               if (reg_data_i[3]) begin
                  w_state_d  = StDone;
                  w_status_d = 2'b00;
               end else if (w_timeout) begin
                  w_state_d = StAbort;
               end else begin
                  w_state_d = StTcsRd;
               end
            end
         end
         StAbort: begin
            reg_we_o         = 1'b1;
            reg_addr_write_o = AddrCmr;
            reg_data_o       = 8'h02;
            w_state_d        = StDone;
            w_status_d       = 2'b10;
         end
         StDone: begin
            done_o    = 1'b1;
            w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   assign busy_o   = (r_state != StIdle);
   assign status_o = r_status;

   always_ff @(posedge clk_i) begin
      if (reg_rst_i) begin
         r_state  <= StIdle;
         r_status <= 2'b00;
         r_ide    <= 1'b0;
         r_rtr    <= 1'b0;
         r_dlc    <= 4'h0;
         r_id     <= '0;
         r_data   <= '0;
         r_cnt    <= 16'h0000;
         r_wait   <= 8'h00;
         r_idx    <= 4'h0;
      end else begin
         r_state  <= w_state_d;
         r_status <= w_status_d;
         if (r_state == StIdle && req.req_valid) begin
            r_ide  <= req.req_ide;
            r_rtr  <= req.req_rtr;
            r_dlc  <= req.req_dlc;
            r_id   <= req.req_id;
            r_data <= req.req_data;
            r_cnt  <= 16'h0000;
         end else if (r_state == StCmd) begin
            r_cnt <= 16'h0000;
         end else if (w_poll && r_cnt != 16'hFFFF) begin
            // Saturate so a full-range timeout never wraps before it is seen.
            r_cnt <= r_cnt + 16'h0001;
         end
         if (r_state == StTbsWt || r_state == StTcsWt) r_wait <= r_wait + 8'h01;
         else                                          r_wait <= 8'h00;
         if (r_state == StLoad) r_idx <= r_idx + 4'h1;
         else                   r_idx <= 4'h0;
      end
   end

endmodule

// File: tb/tb_can_tx_frame_loader.sv
module tb_can_tx_frame_loader;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   can_tx_frame_loader_if rq();

   logic       reg_we, reg_re, tx_we, busy, done;
   logic [7:0] waddr, wdata, raddr, rdata, txd;
   logic [3:0] txa;
   logic [1:0] status;
   logic [7:0] sr_val;

   int comps = 0;
   int fails = 0;

   can_tx_frame_loader #(.RD_LAT(1), .TIMEOUT_CYC(20)) dut (
      .clk_i            (clk),
      .reg_rst_i        (rst),
      .req              (rq),
      .reg_we_o         (reg_we),
      .reg_addr_write_o (waddr),
      .reg_data_o       (wdata),
      .reg_re_o         (reg_re),
      .reg_addr_read_o  (raddr),
      .reg_data_i       (rdata),
      .tx_we_o          (tx_we),
      .tx_addr_o        (txa),
      .tx_data_o        (txd),
      .busy_o           (busy),
      .done_o           (done),
      .status_o         (status)
   );

   // Core model: SR read data valid one cycle after the read strobe.
   always @(posedge clk) rdata <= (reg_re && raddr == 8'd2) ? sr_val : 8'h00;

   // Bus monitor, sampled on the falling edge.
   logic [3:0] tx_idx_q[$];
   logic [7:0] tx_dat_q[$];
   logic [7:0] wr_addr_q[$];
   logic [7:0] wr_dat_q[$];
   int         re_cnt = 0;
   int         multi_cnt = 0;
   always @(negedge clk) begin
      if (!rst) begin
         if (tx_we) begin tx_idx_q.push_back(txa); tx_dat_q.push_back(txd); end
         if (reg_we) begin wr_addr_q.push_back(waddr); wr_dat_q.push_back(wdata); end
         if (reg_re) re_cnt <= re_cnt + 1;
         if ((int'(tx_we) + int'(reg_we) + int'(reg_re)) > 1) multi_cnt <= multi_cnt + 1;
      end
   end

   task automatic send(input logic ide, input logic rtr, input logic [3:0] dlc,
                       input logic [28:0] id, input logic [63:0] data);
      int n = 0;
      @(negedge clk);
      rq.req_ide = ide; rq.req_rtr = rtr; rq.req_dlc = dlc;
      rq.req_id = id; rq.req_data = data; rq.req_valid = 1'b1;
      while (!rq.req_ready && n < 50) begin @(negedge clk); n++; end
      comps++;
      if (n >= 50) begin
         fails++;
         $display("FAIL send_ready: actual ready=0 for 50 cycles, required ready=1");
      end
      @(negedge clk);
      rq.req_valid = 1'b0;
   endtask

   task automatic wait_done(input string name, output logic [1:0] st);
      bit ok = 0;
      st = 2'bxx;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done) begin st = status; ok = 1; break; end
      end
      comps++;
      if (!ok) begin
         fails++;
         $display("FAIL %s_done: actual no done_o in 300 cycles, required done_o", name);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      comps++;
      if ({rq.req_ready, busy, done, status} !== 5'b10000) begin
         fails++;
         $display("FAIL reset_ctl: actual rdy/busy/done/st=%b, required 10000",
                  {rq.req_ready, busy, done, status});
      end
      comps++;
      if ({reg_we, reg_re, tx_we, waddr, wdata, raddr, txa, txd} !== '0) begin
         fails++;
         $display("FAIL reset_bus: actual strobes/addr/data nonzero, required all 0");
      end
      rst = 1'b0;
      @(negedge clk);
      comps++;
      if (rq.req_ready !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle: actual ready=%b busy=%b, required 1/0", rq.req_ready, busy);
      end
   endtask

   task automatic test_ext_frame();
      logic [7:0] e [7] = '{8'h82, 8'h91, 8'hA2, 8'hB3, 8'hC0, 8'hAA, 8'hBB};
      int bt = tx_idx_q.size();
      int bw = wr_addr_q.size();
      logic [1:0] st;
      sr_val = 8'h0C;
      send(1'b1, 1'b0, 4'd2, 29'h12345678, 64'h0000_0000_0000_BBAA);
      wait_done("ext", st);
      comps++;
      if (st !== 2'b00) begin fails++; $display("FAIL ext_status: actual %b, required 00", st); end
      comps++;
      if (tx_idx_q.size() - bt != 7) begin
         fails++; $display("FAIL ext_txcount: actual %0d, required 7", tx_idx_q.size() - bt);
      end
      for (int i = 0; i < 7; i++) begin
         comps++;
         if (bt + i >= tx_idx_q.size() || tx_idx_q[bt+i] !== 4'(i) || tx_dat_q[bt+i] !== e[i]) begin
            fails++;
            $display("FAIL ext_tx%0d: actual idx/data missing or wrong, required %0d/%h", i, i, e[i]);
         end
      end
      comps++;
      if (wr_addr_q.size() - bw != 1 || wr_addr_q[bw] !== 8'd1 || wr_dat_q[bw] !== 8'h01) begin
         fails++;
         $display("FAIL ext_cmr: actual %0d writes, required one CMR<=01", wr_addr_q.size() - bw);
      end
      @(negedge clk);
      comps++;
      if (done !== 1'b0 || rq.req_ready !== 1'b1 || busy !== 1'b0 || status !== 2'b00) begin
         fails++;
         $display("FAIL ext_after: actual done=%b rdy=%b busy=%b st=%b, required 0 1 0 00",
                  done, rq.req_ready, busy, status);
      end
   endtask

   task automatic test_std_rtr();
      logic [7:0] e [3] = '{8'h44, 8'h24, 8'h60};
      int bt = tx_idx_q.size();
      int bw = wr_addr_q.size();
      logic [1:0] st;
      sr_val = 8'h0C;
      send(1'b0, 1'b1, 4'd4, 29'h0000_0123, 64'hFFFF_FFFF_FFFF_FFFF);
      wait_done("rtr", st);
      comps++;
      if (tx_idx_q.size() - bt != 3) begin
         fails++; $display("FAIL rtr_txcount: actual %0d, required 3", tx_idx_q.size() - bt);
      end
      for (int i = 0; i < 3; i++) begin
         comps++;
         if (bt + i >= tx_idx_q.size() || tx_idx_q[bt+i] !== 4'(i) || tx_dat_q[bt+i] !== e[i]) begin
            fails++;
            $display("FAIL rtr_tx%0d: actual idx/data missing or wrong, required %0d/%h", i, i, e[i]);
         end
      end
      comps++;
      if (st !== 2'b00 || wr_addr_q.size() - bw != 1 || wr_dat_q[bw] !== 8'h01) begin
         fails++;
         $display("FAIL rtr_cmr: actual st=%b writes=%0d, required 00 and one CMR<=01",
                  st, wr_addr_q.size() - bw);
      end
   endtask

   task automatic test_dlc_clamp();
      logic [7:0] e [11] = '{8'h0F, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                             8'h05, 8'h06, 8'h07, 8'h08};
      int bt = tx_idx_q.size();
      logic [1:0] st;
      sr_val = 8'h0C;
      send(1'b0, 1'b0, 4'd15, 29'h0, 64'h0807_0605_0403_0201);
      wait_done("dlc15", st);
      comps++;
      if (tx_idx_q.size() - bt != 11) begin
         fails++; $display("FAIL dlc15_txcount: actual %0d, required 11", tx_idx_q.size() - bt);
      end
      for (int i = 0; i < 11; i++) begin
         comps++;
         if (bt + i >= tx_idx_q.size() || tx_idx_q[bt+i] !== 4'(i) || tx_dat_q[bt+i] !== e[i]) begin
            fails++;
            $display("FAIL dlc15_tx%0d: actual idx/data missing or wrong, required %0d/%h",
                     i, i, e[i]);
         end
      end
      comps++;
      if (st !== 2'b00) begin fails++; $display("FAIL dlc15_status: actual %b, required 00", st); end
   endtask

   task automatic test_tbs_timeout();
      int bt = tx_idx_q.size();
      int bw = wr_addr_q.size();
      int br = re_cnt;
      logic [1:0] st;
      sr_val = 8'h00;
      send(1'b0, 1'b0, 4'd1, 29'h55, 64'h11);
      wait_done("tbs_to", st);
      comps++;
      if (st !== 2'b01) begin fails++; $display("FAIL tbs_to_status: actual %b, required 01", st); end
      comps++;
      if (tx_idx_q.size() != bt || wr_addr_q.size() != bw) begin
         fails++;
         $display("FAIL tbs_to_writes: actual tx=%0d reg=%0d, required 0/0",
                  tx_idx_q.size() - bt, wr_addr_q.size() - bw);
      end
      comps++;
      if (re_cnt - br < 5) begin
         fails++; $display("FAIL tbs_to_polls: actual %0d reads, required >=5", re_cnt - br);
      end
   endtask

   task automatic test_tcs_abort();
      logic [7:0] e [6] = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33};
      int bt = tx_idx_q.size();
      int bw = wr_addr_q.size();
      logic [1:0] st;
      sr_val = 8'h04;
      send(1'b1, 1'b0, 4'd1, 29'h0, 64'h33);
      wait_done("abort", st);
      comps++;
      if (st !== 2'b10) begin fails++; $display("FAIL abort_status: actual %b, required 10", st); end
      comps++;
      if (tx_idx_q.size() - bt != 6 || tx_dat_q[bt] !== e[0] || tx_dat_q[bt+5] !== e[5]) begin
         fails++;
         $display("FAIL abort_load: actual %0d writes, required 6 (81..33)", tx_idx_q.size() - bt);
      end
      comps++;
      if (wr_addr_q.size() - bw != 2 || wr_addr_q[bw] !== 8'd1 || wr_dat_q[bw] !== 8'h01 ||
          wr_addr_q[bw+1] !== 8'd1 || wr_dat_q[bw+1] !== 8'h02) begin
         fails++;
         $display("FAIL abort_cmr: actual %0d writes, required CMR<=01 then CMR<=02",
                  wr_addr_q.size() - bw);
      end
   endtask

   task automatic test_reset_mid_load();
      logic [7:0] e [4] = '{8'h01, 8'hFF, 8'hE0, 8'h5A};
      int  n = 0;
      int  bt;
      logic [1:0] st;
      sr_val = 8'h0C;
      send(1'b1, 1'b0, 4'd8, 29'h1ABCDEF0, 64'hFFEE_DDCC_BBAA_9988);
      comps++;
      if (status !== 2'b10 || busy !== 1'b1) begin
         fails++;
         $display("FAIL hold_status: actual st=%b busy=%b, required 10/1", status, busy);
      end
      while (!(tx_we && txa == 4'd3) && n < 100) begin @(negedge clk); n++; end
      comps++;
      if (n >= 100) begin fails++; $display("FAIL midload_reach: actual idx3 not seen, required"); end
      rst = 1'b1;
      @(negedge clk);
      comps++;
      if ({tx_we, reg_we, reg_re} !== 3'b000 || rq.req_ready !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL midload_rst: actual tx/we/re=%b rdy=%b busy=%b, required 000 1 0",
                  {tx_we, reg_we, reg_re}, rq.req_ready, busy);
      end
      rst = 1'b0;
      bt = tx_idx_q.size();
      send(1'b0, 1'b0, 4'd1, 29'h7FF, 64'h5A);
      wait_done("reload", st);
      comps++;
      if (tx_idx_q.size() - bt != 4 || st !== 2'b00) begin
         fails++;
         $display("FAIL reload_count: actual %0d writes st=%b, required 4 / 00",
                  tx_idx_q.size() - bt, st);
      end
      for (int i = 0; i < 4; i++) begin
         comps++;
         if (bt + i >= tx_idx_q.size() || tx_idx_q[bt+i] !== 4'(i) || tx_dat_q[bt+i] !== e[i]) begin
            fails++;
            $display("FAIL reload_tx%0d: actual idx/data missing or wrong, required %0d/%h",
                     i, i, e[i]);
         end
      end
   endtask

   initial begin
      rq.req_valid = 1'b0; rq.req_ide = 1'b0; rq.req_rtr = 1'b0;
      rq.req_dlc = 4'h0; rq.req_id = '0; rq.req_data = '0;
      sr_val = 8'h00;
      rst = 1'b1;
      test_reset();
      test_ext_frame();
      test_std_rtr();
      test_dlc_clamp();
      test_tbs_timeout();
      test_tcs_abort();
      test_reset_mid_load();
      comps++;
      if (multi_cnt != 0) begin
         fails++;
         $display("FAIL strobe_excl: actual %0d overlapping cycles, required 0", multi_cnt);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
      $finish;
   end
endmodule
